int_freelist: RTL and testbench

Integer physical-register free list for the rename stage. It hands out free physical register indices (`iprIdx_t`, IPHYREG_NUM entries) to rename lanes, takes back indices freed at commit, and rewinds speculative allocations on a pipeline squash. It sits beside the rename alias table and feeds its destination-remap path. The ROB drives commit and free; the flush logic drives squash.

---
 rtl/int_freelist_pkg.sv | 19 +
 rtl/lane_prefix_cnt.sv | 24 ++
 rtl/int_freelist.sv | 181 ++++++++++++++++++
 tb/tb_int_freelist.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_freelist_pkg.sv
// Shared core configuration for the integer rename free list.
// Holds the physical register count, free-list depth and the index/pointer
// types used by the rename stage.
package int_freelist_pkg;

  // Number of integer physical registers in the core.
  localparam int IPHYREG_NUM_CFG = 64;

  // Free-list depth: everything except the 32 architecturally mapped regs.
  localparam int FL_DEPTH = IPHYREG_NUM_CFG - 32;
  localparam int FL_IDX_W = $clog2(FL_DEPTH);

  // Pointer type with one extra wrap bit to tell full from empty.
  typedef logic [FL_IDX_W:0] flPtr_t;

  // Physical register index.
  typedef logic [$clog2(IPHYREG_NUM_CFG)-1:0] iprIdx_t;

endpackage

// File: rtl/lane_prefix_cnt.sv
// Per-lane exclusive popcount of a valid vector: lane k receives the number
// of valid lanes below it, which is its offset into a compacted sequence.
// The total count of valid lanes is also provided.
module lane_prefix_cnt #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         i_vld,
  output logic [N-1:0][CW-1:0] o_pfx,
  output logic [CW-1:0]        o_total
);

  // Running sum over the lanes, emitted before each lane adds itself.
  always_comb begin
    logic [CW-1:0] v_acc;
    v_acc = '0;
    for (int k = 0; k < N; k++) begin
      o_pfx[k] = v_acc;
      v_acc    = v_acc + CW'(i_vld[k]);
    end
    o_total = v_acc;
  end

endmodule

// File: rtl/int_freelist.sv
// Integer physical-register free list for the rename stage.
// Circular buffer with a speculative head (allocation), a committed head
// (rewind point for squash) and a tail (commit-time frees). Allocation is
// combinational and all-or-nothing across the rename lanes.
// Optional build macro FREELIST_DUPCHK_EN adds a per-register free vector
// that flags double frees and allocation of non-free registers on o_err.
module int_freelist
  import int_freelist_pkg::*;
#(
  parameter  int IPHYREG_NUM  = IPHYREG_NUM_CFG,
  parameter  int RENAME_WIDTH = 2,
  parameter  int COMMIT_WIDTH = 2,
  localparam int DEPTH        = IPHYREG_NUM - 32,
  localparam int IDX_W        = $clog2(DEPTH),
  localparam int PTR_W        = IDX_W + 1,
  localparam int IPR_W        = $clog2(IPHYREG_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [RENAME_WIDTH-1:0]             i_alloc_req,
  output logic                                o_alloc_ready,
  output logic [RENAME_WIDTH-1:0][IPR_W-1:0]  o_alloc_prd,
  input  logic [COMMIT_WIDTH-1:0]             i_commit_vld,
  input  logic [COMMIT_WIDTH-1:0]             i_free_vld,
  input  logic [COMMIT_WIDTH-1:0][IPR_W-1:0]  i_free_prd,
  input  logic                                i_squash,
  output logic [PTR_W-1:0]                    o_free_count,
  output logic                                o_err
);

  localparam int ACW = $clog2(RENAME_WIDTH + 1);
  localparam int CCW = $clog2(COMMIT_WIDTH + 1);

  logic [IPR_W-1:0]                   r_entry [DEPTH];
  logic [PTR_W-1:0]                   r_spec_head;
  logic [PTR_W-1:0]                   r_arch_head;
  logic [PTR_W-1:0]                   r_tail;

  logic [RENAME_WIDTH-1:0][ACW-1:0]   w_alloc_pfx;
  logic [ACW-1:0]                     w_alloc_total;
  logic [COMMIT_WIDTH-1:0][CCW-1:0]   w_free_pfx;
  logic [CCW-1:0]                     w_free_total;
  logic [CCW-1:0]                     w_cmt_total;
  logic [PTR_W-1:0]                   w_alloc_ptr [RENAME_WIDTH];
  logic [PTR_W-1:0]                   w_free_ptr  [COMMIT_WIDTH];
  logic [PTR_W-1:0]                   w_free_count;
  logic                               w_alloc_ready;
  logic                               w_fire;

  lane_prefix_cnt #(.N(RENAME_WIDTH), .CW(ACW)) u_alloc_pfx (
    .i_vld   (i_alloc_req),
    .o_pfx   (w_alloc_pfx),
    .o_total (w_alloc_total)
  );

  lane_prefix_cnt #(.N(COMMIT_WIDTH), .CW(CCW)) u_free_pfx (
    .i_vld   (i_free_vld),
    .o_pfx   (w_free_pfx),
    .o_total (w_free_total)
  );

  // Frees are not bypassed: availability is judged from registered state only.
  assign w_free_count  = r_tail - r_spec_head;
  assign w_alloc_ready = (w_free_count >= PTR_W'(RENAME_WIDTH)) && !i_squash;
  assign w_fire        = w_alloc_ready && (|i_alloc_req);

  assign o_free_count  = w_free_count;
  assign o_alloc_ready = w_alloc_ready;

  // Compacted read: each requesting lane takes the next entry after the
  // requesting lanes below it; free lanes write compacted after the tail.
  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_alloc_ptr[k] = r_spec_head + PTR_W'(w_alloc_pfx[k]);
      o_alloc_prd[k] = r_entry[w_alloc_ptr[k][IDX_W-1:0]];
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_free_ptr[k] = r_tail + PTR_W'(w_free_pfx[k]);
    end
  end

  // Pointer update: commit advances the committed head, squash rewinds the
  // speculative head to it (including this cycle's commits), frees grow the tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_spec_head <= '0;
      r_arch_head <= '0;
      r_tail      <= PTR_W'(DEPTH);
    end else begin
      r_arch_head <= r_arch_head + PTR_W'(w_cmt_total);
      if (i_squash) begin
        r_spec_head <= r_arch_head + PTR_W'(w_cmt_total);
      end else if (w_fire) begin
        r_spec_head <= r_spec_head + PTR_W'(w_alloc_total);
      end else begin
        r_spec_head <= r_spec_head;
      end
      r_tail <= r_tail + PTR_W'(w_free_total);
    end
  end

  // Entry storage: reset fills with regs 32..N-1, frees write at the tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= IPR_W'(32 + i);
      end
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (i_free_vld[k]) begin
          r_entry[w_free_ptr[k][IDX_W-1:0]] <= i_free_prd[k];
        end
      end
    end
  end

`ifdef FREELIST_DUPCHK_EN
  logic [COMMIT_WIDTH-1:0][CCW-1:0]   w_cmt_pfx;
  logic [PTR_W-1:0]                   w_cmt_ptr [COMMIT_WIDTH];
  logic [IPHYREG_NUM-1:0]             r_free_vec;
  logic [IPHYREG_NUM-1:0]             r_arch_vec;
  logic [IPHYREG_NUM-1:0]             w_free_vec_nxt;
  logic [IPHYREG_NUM-1:0]             w_arch_vec_nxt;
  logic [IPHYREG_NUM-1:0]             w_alloc_mask;
  logic [IPHYREG_NUM-1:0]             w_cmt_mask;
  logic [IPHYREG_NUM-1:0]             w_free_mask;
  logic                               w_err_ev;
  logic                               r_err;

  lane_prefix_cnt #(.N(COMMIT_WIDTH), .CW(CCW)) u_cmt_pfx (
    .i_vld   (i_commit_vld),
    .o_pfx   (w_cmt_pfx),
    .o_total (w_cmt_total)
  );

  // Build per-register masks for this cycle's allocs, commits and frees, and
  // derive the next speculative and committed free vectors.
  always_comb begin
    w_alloc_mask = '0;
    w_cmt_mask   = '0;
    w_free_mask  = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_alloc_mask = w_alloc_mask |
        ({{(IPHYREG_NUM-1){1'b0}}, (w_fire & i_alloc_req[k])} << o_alloc_prd[k]);
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_cmt_ptr[k] = r_arch_head + PTR_W'(w_cmt_pfx[k]);
      w_cmt_mask   = w_cmt_mask |
        ({{(IPHYREG_NUM-1){1'b0}}, i_commit_vld[k]} << r_entry[w_cmt_ptr[k][IDX_W-1:0]]);
      w_free_mask  = w_free_mask |
        ({{(IPHYREG_NUM-1){1'b0}}, i_free_vld[k]} << i_free_prd[k]);
    end
    w_err_ev       = (|(w_free_mask & r_free_vec)) | (|(w_alloc_mask & ~r_free_vec));
    w_arch_vec_nxt = (r_arch_vec & ~w_cmt_mask) | w_free_mask;
    if (i_squash) begin
      w_free_vec_nxt = w_arch_vec_nxt;
    end else begin
      w_free_vec_nxt = (r_free_vec & ~w_alloc_mask) | w_free_mask;
    end
  end

  // Free-vector state and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_free_vec <= {{(IPHYREG_NUM-32){1'b1}}, 32'h0000_0000};
      r_arch_vec <= {{(IPHYREG_NUM-32){1'b1}}, 32'h0000_0000};
      r_err      <= 1'b0;
    end else begin
      r_free_vec <= w_free_vec_nxt;
      r_arch_vec <= w_arch_vec_nxt;
      r_err      <= r_err | w_err_ev;
    end
  end

  assign o_err = r_err;
`else
  assign w_cmt_total = CCW'($countones(i_commit_vld));
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_int_freelist.sv
// Self-checking bench for int_freelist (IPHYREG_NUM=64, 2 rename, 2 commit).
// Directed vector table, hand-written corner sequences, then randomized
// traffic checked against a queue-based model of free/in-flight/held regs.
module tb_int_freelist;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req, cmt, fv;
  logic [1:0][5:0]  fprd;
  logic             sq;
  logic             rdy;
  logic [1:0][5:0]  prd;
  logic [5:0]       cnt;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;

  int_freelist dut (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_req  (req),
    .o_alloc_ready(rdy),
    .o_alloc_prd  (prd),
    .i_commit_vld (cmt),
    .i_free_vld   (fv),
    .i_free_prd   (fprd),
    .i_squash     (sq),
    .o_free_count (cnt),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_b;
    logic [1:0] req, cmt, fv;
    logic [5:0] fp0, fp1;
    bit         sq;
    int         cnt;
    bit         rdy;
    logic [1:0] chk;
    int         p0, p1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    req = 2'b00; cmt = 2'b00; fv = 2'b00; fprd = '0; sq = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input int ecnt, input bit erdy,
                         input logic [1:0] lanes, input int e0, input int e1);
    check({tag, ".count"}, 32'(cnt), 32'(ecnt));
    check({tag, ".ready"}, 32'(rdy), 32'(erdy));
    if (lanes[0]) check({tag, ".prd0"}, 32'(prd[0]), 32'(e0));
    if (lanes[1]) check({tag, ".prd1"}, 32'(prd[1]), 32'(e1));
  endtask

  vec_t tbl[$];

  // Reference model state
  int freeq[$];
  int infl[$];
  int held[$];

  initial begin
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // ---------------- vector table ----------------
    //                rst  req    cmt    fv     fp0 fp1 sq cnt rdy chk   p0  p1
    tbl.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 32, 1'b1, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 32, 1'b1, 2'b11, 32, 33});
    tbl.push_back('{1'b0, 2'b10, 2'b00, 2'b00, 0, 0, 1'b0, 30, 1'b1, 2'b10, 0, 34});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 29, 1'b1, 2'b00, 0, 0});
    // squash rewinds to committed head plus this cycle's commits
    tbl.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 32, 1'b1, 2'b11, 32, 33});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 30, 1'b1, 2'b11, 34, 35});
    tbl.push_back('{1'b0, 2'b00, 2'b11, 2'b00, 0, 0, 1'b1, 28, 1'b0, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 30, 1'b1, 2'b11, 34, 35});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 28, 1'b1, 2'b00, 0, 0});
    // squash together with a request: no allocation that cycle
    tbl.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 28, 1'b0, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 30, 1'b1, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0, 30, 1'b1, 2'b01, 34, 0});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 29, 1'b1, 2'b00, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_b) do_reset();
      req = tbl[i].req; cmt = tbl[i].cmt; fv = tbl[i].fv;
      fprd[0] = tbl[i].fp0; fprd[1] = tbl[i].fp1; sq = tbl[i].sq;
      #2;
      chk_out($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].rdy, tbl[i].chk, tbl[i].p0, tbl[i].p1);
      check($sformatf("vec%0d.err", i), 32'(err), 32'd0);
      tick();
    end
    idle();

    // ---------------- drain, then free with wrap ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req = 2'b11;
      #2;
      chk_out($sformatf("fill%0d", i), 32 - 2 * i, 1'b1, 2'b11, 32 + 2 * i, 33 + 2 * i);
      tick();
    end
    req = 2'b11; fv = 2'b11; fprd[0] = 6'd5; fprd[1] = 6'd7;
    #2;
    chk_out("empty_free", 0, 1'b0, 2'b00, 0, 0);
    tick();
    idle(); req = 2'b11;
    #2;
    chk_out("wrap_alloc", 2, 1'b1, 2'b11, 5, 7);
    tick();
    idle(); fv = 2'b10; fprd[1] = 6'd9;
    #2;
    chk_out("empty2", 0, 1'b0, 2'b00, 0, 0);
    tick();
    idle(); fv = 2'b01; fprd[0] = 6'd3;
    #2;
    chk_out("one_free", 1, 1'b0, 2'b00, 0, 0);
    tick();
    idle(); req = 2'b11;
    #2;
    chk_out("lane_free_order", 2, 1'b1, 2'b11, 9, 3);
    tick();
    idle();
    #2;
    chk_out("empty3", 0, 1'b0, 2'b00, 0, 0);

    // ---------------- reset mid-operation ----------------
    do_reset();
    req = 2'b11;
    #2;
    chk_out("mid_reset", 32, 1'b1, 2'b11, 32, 33);
    check("mid_reset.err", 32'(err), 32'd0);
    tick();
    idle();

`ifdef FREELIST_DUPCHK_EN
    // ---------------- duplicate-free detection ----------------
    do_reset();
    fv = 2'b01; fprd[0] = 6'd40;
    #2;
    check("dup.err_same_cycle", 32'(err), 32'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("dup.err_sticky%0d", i), 32'(err), 32'd1);
      tick();
    end
    do_reset();
    #2;
    check("dup.err_cleared", 32'(err), 32'd0);
`endif

    // ---------------- randomized vs. model ----------------
    do_reset();
    freeq = {}; infl = {}; held = {};
    for (int r = 32; r < 64; r++) freeq.push_back(r);
    for (int r = 0; r < 32; r++)  held.push_back(r);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      int nc, nf, nfree_ok, exp_cnt, pos;
      bit exp_rdy;
      int fvals[2];

      req = 2'($urandom);
      sq  = ($urandom_range(0, 15) == 0);
      cmt = 2'($urandom);
      if (infl.size() == 0) cmt = 2'b00;
      else if (infl.size() == 1 && cmt == 2'b11) cmt = 2'b01 << $urandom_range(0, 1);
      nc = $countones(cmt);

      fv = 2'($urandom | $urandom);
      nfree_ok = held.size() - 32;
      if (nfree_ok <= 0) fv = 2'b00;
      else if (nfree_ok == 1 && fv == 2'b11) fv = 2'b01 << $urandom_range(0, 1);
      nf = 0;
      fprd = '0;
      for (int k = 0; k < 2; k++) begin
        if (fv[k]) begin
          pos = $urandom_range(0, held.size() - 1);
          fvals[nf] = held[pos];
          fprd[k] = 6'(held[pos]);
          held.delete(pos);
          nf++;
        end
      end

      exp_cnt = freeq.size();
      exp_rdy = (exp_cnt >= 2) && !sq;
      #2;
      check("rnd.count", 32'(cnt), 32'(exp_cnt));
      check("rnd.ready", 32'(rdy), 32'(exp_rdy));
      check("rnd.err", 32'(err), 32'd0);
      if (exp_rdy) begin
        int off;
        off = 0;
        for (int k = 0; k < 2; k++) begin
          if (req[k]) begin
            check($sformatf("rnd.prd%0d", k), 32'(prd[k]), 32'(freeq[off]));
            off++;
          end
        end
      end

      // model update: commits retire oldest in-flight regs
      for (int i = 0; i < nc; i++) held.push_back(infl.pop_front());
      if (sq) begin
        freeq = {infl, freeq};
        infl = {};
      end else if (exp_rdy) begin
        for (int i = 0; i < $countones(req); i++) infl.push_back(freeq.pop_front());
      end
      for (int i = 0; i < nf; i++) freeq.push_back(fvals[i]);

      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
